chunked_serial_adder: RTL and testbench

//   Parametrised multi-cycle adder/subtractor. Adds two WIDTH-bit operands

---
 rtl/chunked_serial_adder.sv | 119 +++++++++++
 tb/tb_chunked_serial_adder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle add/subtract, CHUNK bits per clock.
// LSB chunk first; the carry is held in a register between chunks.
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             subtract,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int NCHUNKS = WIDTH / CHUNK;
  localparam int KW = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic [KW-1:0]    k;
  logic             carry;
  logic [CHUNK-1:0] ach;
  logic [CHUNK-1:0] bch;
  logic [CHUNK-1:0] sch;
  logic             cch;
  logic             ovf_nxt;

  always_comb begin
    ach = '0;
    bch = '0;
    for (int i = 0; i < NCHUNKS; i++) begin
      if (k == KW'(i)) begin
        ach = opa[i*CHUNK +: CHUNK];
        bch = opb[i*CHUNK +: CHUNK];
      end
    end
  end

  // The only carry chain in the design: CHUNK bits wide.
  assign {cch, sch} = {1'b0, ach}
                    + {1'b0, bch}
                    + {{CHUNK{1'b0}}, carry};

  always_comb begin
    res_nxt = res;
    for (int i = 0; i < NCHUNKS; i++) begin
      if (k == KW'(i)) begin
        res_nxt[i*CHUNK +: CHUNK] = sch;
      end
    end
  end

  // opb already holds the inverted operand when subtracting.
  assign ovf_nxt = (opa[WIDTH-1] == opb[WIDTH-1])
                && (res_nxt[WIDTH-1] != opa[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opa      <= '0;
      opb      <= '0;
      res      <= '0;
      k        <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        RUN: begin
          res   <= res_nxt;
          carry <= cch;
          k     <= k + 1'b1;
          if (k == KLAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            sum      <= res_nxt;
            carryout <= cch;
            overflow <= ovf_nxt;
          end
        end
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            opa   <= a;
            opb   <= b ^ {WIDTH{subtract}};
            carry <= subtract | carryin;
            k     <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb_chunked_serial_adder: scoreboard bench for three adder shapes.
// Directed corner cases on 32/4, random ops on 32/4, 8/1 and 16/16.
module tb_chunked_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        s0, ci0, su0, bz0, d0, co0, ov0;
  logic [31:0] a0, b0, y0;
  logic        s1, ci1, su1, bz1, d1, co1, ov1;
  logic [7:0]  a1, b1, y1;
  logic        s2, ci2, su2, bz2, d2, co2, ov2;
  logic [15:0] a2, b2, y2;

  chunked_serial_adder #(.WIDTH(32), .CHUNK(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(s0), .a(a0), .b(b0),
    .carryin(ci0), .subtract(su0), .busy(bz0), .done(d0),
    .sum(y0), .carryout(co0), .overflow(ov0)
  );

  chunked_serial_adder #(.WIDTH(8), .CHUNK(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1),
    .carryin(ci1), .subtract(su1), .busy(bz1), .done(d1),
    .sum(y1), .carryout(co1), .overflow(ov1)
  );

  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) u2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .a(a2), .b(b2),
    .carryin(ci2), .subtract(su2), .busy(bz2), .done(d2),
    .sum(y2), .carryout(co2), .overflow(ov2)
  );

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int errors = 0;
  int checks = 0;
  int dcnt0  = 0;

  // Reference: plain integer add, signed range test for overflow.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b,
                                 logic ci, logic su);
    longint unsigned m, ua, ub, cin, tot;
    longint sa, sb, st, hi, lo;
    exp_t e;
    m   = (64'd1 << w) - 1;
    ua  = {32'd0, a} & m;
    ub  = {32'd0, (su ? ~b : b)} & m;
    cin = su ? 64'd1 : {63'd0, ci};
    tot = ua + ub + cin;
    hi  = longint'(m >> 1);
    lo  = -longint'((m + 1) / 2);
    sa  = (ua > m >> 1) ? longint'(ua) - longint'(m + 1) : longint'(ua);
    sb  = (ub > m >> 1) ? longint'(ub) - longint'(m + 1) : longint'(ub);
    st  = sa + sb + longint'(cin);
    e.s = 32'(tot & m);
    e.c = ((tot >> w) & 64'd1) != 0;
    e.v = (st > hi) || (st < lo);
    return e;
  endfunction

  task automatic chk(string nm, longint unsigned got, longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && d0) begin
      dcnt0++;
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done0_unexpected: got done=1 want no pulse");
      end else begin
        e = q0.pop_front();
        chk("sum0", y0, e.s);
        chk("cout0", co0, e.c);
        chk("ovf0", ov0, e.v);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && d1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done1_unexpected: got done=1 want no pulse");
      end else begin
        e = q1.pop_front();
        chk("sum1", y1, e.s);
        chk("cout1", co1, e.c);
        chk("ovf1", ov1, e.v);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && d2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done2_unexpected: got done=1 want no pulse");
      end else begin
        e = q2.pop_front();
        chk("sum2", y2, e.s);
        chk("cout2", co2, e.c);
        chk("ovf2", ov2, e.v);
      end
    end
  end

  function automatic logic dn(int w);
    case (w)
      0: return d0;
      1: return d1;
      default: return d2;
    endcase
  endfunction

  function automatic logic bsy(int w);
    case (w)
      0: return bz0;
      1: return bz1;
      default: return bz2;
    endcase
  endfunction

  function automatic logic [31:0] sm(int w);
    case (w)
      0: return y0;
      1: return {24'd0, y1};
      default: return {16'd0, y2};
    endcase
  endfunction

  task automatic drive(int w, logic [31:0] a, logic [31:0] b,
                       logic ci, logic su, logic st);
    case (w)
      0: begin a0 = a; b0 = b; ci0 = ci; su0 = su; s0 = st; end
      1: begin a1 = a[7:0]; b1 = b[7:0]; ci1 = ci; su1 = su; s1 = st; end
      default: begin
        a2 = a[15:0]; b2 = b[15:0]; ci2 = ci; su2 = su; s2 = st;
      end
    endcase
  endtask

  task automatic push(int w, exp_t e);
    case (w)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic go(int w, logic [31:0] a, logic [31:0] b,
                    logic ci, logic su, int hold);
    int lat, lw, wd;
    logic [31:0] old;
    lw = (w == 2) ? 1 : 8;
    wd = (w == 0) ? 32 : (w == 1) ? 8 : 16;
    @(negedge clk);
    drive(w, a, b, ci, su, 1'b1);
    push(w, model(wd, a, b, ci, su));
    old = sm(w);
    @(posedge clk);
    #1;
    lat = 0;
    chk("busy_on_accept", bsy(w), 1);
    for (int h = 0; h < hold; h++) begin
      drive(w, $urandom, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b1);
      @(posedge clk);
      #1;
      lat++;
    end
    drive(w, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    while (!dn(w) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lw > 1 && lat == lw / 2 && !dn(w))
        chk("sum_stable_busy", sm(w), old);
    end
    chk("latency", lat, lw);
  endtask

  task automatic dir(string nm, logic [31:0] s, logic c, logic v);
    chk({nm, "_sum"}, y0, s);
    chk({nm, "_cout"}, co0, c);
    chk({nm, "_ovf"}, ov0, v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int saved;
    rst_n = 1'b0;
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
    drive(1, 0, 0, 1'b0, 1'b0, 1'b0);
    drive(2, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bz0, 0);
    chk("rst_done", d0, 0);
    chk("rst_sum", y0, 0);
    chk("rst_cout", co0, 0);
    chk("rst_ovf", ov0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    go(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 0);
    dir("t1", 32'h0, 1'b1, 1'b0);
    go(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 0);
    dir("t2a", 32'h8000_0000, 1'b0, 1'b1);
    go(0, 32'h0, 32'h0, 1'b1, 1'b0, 0);
    dir("t2b", 32'h1, 1'b0, 1'b0);
    go(0, 32'h5, 32'h7, 1'b0, 1'b1, 0);
    dir("t3a", 32'hFFFF_FFFE, 1'b0, 1'b0);
    go(0, 32'h8000_0000, 32'h1, 1'b1, 1'b1, 0);
    dir("t3b", 32'h7FFF_FFFF, 1'b1, 1'b1);

    go(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 3);
    dir("t4_hold", 32'h2345_6789, 1'b0, 1'b0);
    go(0, 32'h1, 32'h2, 1'b0, 1'b0, 0);
    dir("t4_b2b", 32'h3, 1'b0, 1'b0);

    @(negedge clk);
    drive(0, 32'hAAAA_0000, 32'h0000_5555, 1'b0, 1'b0, 1'b1);
    push(0, model(32, 32'hAAAA_0000, 32'h0000_5555, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bz0, 0);
    chk("abort_done", d0, 0);
    chk("abort_sum", y0, 0);
    q0.delete();
    saved = dcnt0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_done", dcnt0, saved);
    go(0, 32'd10, 32'd20, 1'b0, 1'b0, 0);
    dir("t5_after", 32'd30, 1'b0, 1'b0);

    for (int w = 0; w < 3; w++) begin
      repeat (1000) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        go(w, $urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 0);
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
